// File: rtl/mult_pkg.sv
// Shared definitions for the sequential arithmetic blocks: FSM state encoding
// and the iteration-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int ctr_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one partial product per cycle on operand
// magnitudes, with the sign applied to the full 2*WIDTH result at the end.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero
);

    localparam int            CW   = ctr_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state_r;
    state_t               state_s;
    logic [CW-1:0]        count_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [WIDTH-1:0]     mcand_r;
    logic                 neg_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 zero_r;
    logic                 busy_r;
    logic                 done_r;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   prod_step_s;
    logic [2*WIDTH-1:0]   result_s;

    // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                    input logic sgn);
        if (sgn && x[WIDTH-1]) begin
            return ~x + WIDTH'(1);
        end else begin
            return x;
        end
    endfunction

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
    assign zero = zero_r;

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == LAST) begin
                    state_s = FIX;
                end else begin
                    state_s = RUN;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // One shift-add step; the extra sum bit keeps the carry out of the upper half.
    always_comb begin
        sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
        if (prod_r[0]) begin
            sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
        end
        prod_step_s = {sum_s, prod_r[WIDTH-1:1]};
    end

    // Final sign correction across the whole double-width product
    always_comb begin
        result_s = prod_r;
        if (neg_r) begin
            result_s = ~prod_r + (2*WIDTH)'(1);
        end else begin
            result_s = prod_r;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            count_r <= {CW{1'b0}};
            prod_r  <= {(2*WIDTH){1'b0}};
            mcand_r <= {WIDTH{1'b0}};
            neg_r   <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            zero_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_r == FIX);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        prod_r  <= {{WIDTH{1'b0}}, magnitude(b, is_signed)};
                        mcand_r <= magnitude(a, is_signed);
                        neg_r   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        count_r <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    prod_r  <= prod_step_s;
                    count_r <= count_r + CW'(1);
                end
                FIX: begin
                    hi_r   <= result_s[2*WIDTH-1:WIDTH];
                    lo_r   <= result_s[WIDTH-1:0];
                    zero_r <= (result_s == {(2*WIDTH){1'b0}});
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Directed and reference-model bench for mult_seq at WIDTH=32 and WIDTH=8.
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_signed;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, zero;
    logic        start8, signed8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy8, done8, zero8;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] p;
    } vec_t;

    always #5 clk = ~clk;

    mult_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .zero(zero)
    );

    mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(signed8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .zero(zero8)
    );

    // Caller is positioned at a negedge; start is sampled at the next posedge.
    task automatic op32(input logic [31:0] av, input logic [31:0] bv,
                        input logic sg, output int lat);
        a = av; b = bv; is_signed = sg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat >= 100) begin
            n_fail++;
            $display("FAIL op32_timeout: no done for a=%h b=%h", av, bv);
        end
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                       input logic sg, output int lat);
        a8 = av; b8 = bv; signed8 = sg; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat >= 40) begin
            n_fail++;
            $display("FAIL op8_timeout: no done for a=%h b=%h", av, bv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = 32'd0; b = 32'd0;
        start8 = 1'b0; signed8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, zero, hi, lo} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset32: got busy=%b done=%b zero=%b hi=%h lo=%h, want all 0",
                     busy, done, zero, hi, lo);
        end
        n_checks++;
        if ({busy8, done8, zero8, hi8, lo8} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset8: got busy=%b done=%b zero=%b hi=%h lo=%h, want all 0",
                     busy8, done8, zero8, hi8, lo8);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        vec_t tbl[10] = '{
            '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001},
            '{32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFF_FFFFFFF1},
            '{32'h00000005, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFF_FFFFFFF1},
            '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000},
            '{32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000},
            '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001},
            '{32'hFFFFFFFF, 32'h00000001, 1'b0, 64'h00000000_FFFFFFFF},
            '{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFF_FFFFFFFF},
            '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC0000000_80000000},
            '{32'h00000000, 32'h00001234, 1'b1, 64'h00000000_00000000}
        };
        int lat;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op32(tbl[i].a, tbl[i].b, tbl[i].s, lat);
            n_checks++;
            if (lat !== 33) begin
                n_fail++;
                $display("FAIL latency32[%0d]: got %0d, want 33", i, lat);
            end
            n_checks++;
            if ({hi, lo} !== tbl[i].p) begin
                n_fail++;
                $display("FAIL product32[%0d]: got %h_%h, want %h", i, hi, lo, tbl[i].p);
            end
            n_checks++;
            if (zero !== (tbl[i].p == 64'd0)) begin
                n_fail++;
                $display("FAIL zero32[%0d]: got %b, want %b", i, zero, tbl[i].p == 64'd0);
            end
            @(negedge clk);
            n_checks++;
            if ({done, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL done_pulse[%0d]: got done=%b busy=%b, want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        op32(32'd0, 32'h1234, 1'b0, lat);
        n_checks++;
        if ({hi, lo, zero} !== {64'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_first: got hi=%h lo=%h zero=%b, want 0 0 1", hi, lo, zero);
        end
        op32(32'd7, 32'd6, 1'b0, lat);
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d, want 33", lat);
        end
        n_checks++;
        if ({hi, lo, zero} !== {32'd0, 32'd42, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_second: got hi=%h lo=%h zero=%b, want 0 42 0", hi, lo, zero);
        end
    endtask

    task automatic test_ignore_start();
        int n_done = 0;
        @(negedge clk);
        a = 32'd3; b = 32'd4; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++;
        if ({busy, hi, lo} !== {1'b1, 32'd0, 32'd42}) begin
            n_fail++;
            $display("FAIL hold_in_run: got busy=%b hi=%h lo=%h, want 1 0 2a", busy, hi, lo);
        end
        a = 32'd100; b = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        n_checks++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL start_ignored: got %0d done pulses, want 1", n_done);
        end
        n_checks++;
        if (lo !== 32'd12) begin
            n_fail++;
            $display("FAIL start_ignored_result: got lo=%0d, want 12", lo);
        end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        int lat;
        @(negedge clk);
        a = 32'd9; b = 32'd9; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, zero, hi, lo} !== 67'd0) begin
            n_fail++;
            $display("FAIL abort_reset: got busy=%b done=%b zero=%b hi=%h lo=%h, want all 0",
                     busy, done, zero, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", n_done);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        op32(32'd11, 32'd13, 1'b0, lat);
        n_checks++;
        if (lat !== 33 || lo !== 32'd143 || hi !== 32'd0) begin
            n_fail++;
            $display("FAIL after_reset: got lat=%0d hi=%h lo=%0d, want 33 0 143", lat, hi, lo);
        end
    endtask

    task automatic test_width8();
        logic [7:0]  va[4] = '{8'h80, 8'hFF, 8'h80, 8'h00};
        logic [7:0]  vb[4] = '{8'h7F, 8'hFF, 8'h80, 8'hFB};
        logic        vs[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] vp[4] = '{16'hC080, 16'hFE01, 16'h4000, 16'h0000};
        int lat;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op8(va[i], vb[i], vs[i], lat);
            n_checks++;
            if (lat !== 9 || {hi8, lo8} !== vp[i] || zero8 !== (vp[i] == 16'd0)) begin
                n_fail++;
                $display("FAIL w8[%0d]: got lat=%0d prod=%h zero=%b, want 9 %h %b",
                         i, lat, {hi8, lo8}, zero8, vp[i], vp[i] == 16'd0);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0]        ra, rb;
        logic [7:0]         ra8, rb8;
        logic               rs;
        logic signed [63:0] ref64;
        logic signed [15:0] ref16;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(1));
            if (i == 0) ra = 32'h80000000;
            if (rs) ref64 = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
            else    ref64 = $signed({32'd0, ra} * {32'd0, rb});
            op32(ra, rb, rs, lat);
            n_checks++;
            if ({hi, lo} !== ref64) begin
                n_fail++;
                $display("FAIL rand32[%0d]: a=%h b=%h s=%b got %h_%h, want %h",
                         i, ra, rb, rs, hi, lo, ref64);
            end
        end
        for (int i = 0; i < 60; i++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom); rs = 1'($urandom_range(1));
            if (rs) ref16 = $signed({{8{ra8[7]}}, ra8}) * $signed({{8{rb8[7]}}, rb8});
            else    ref16 = $signed({8'd0, ra8} * {8'd0, rb8});
            op8(ra8, rb8, rs, lat);
            n_checks++;
            if ({hi8, lo8} !== ref16) begin
                n_fail++;
                $display("FAIL rand8[%0d]: a=%h b=%h s=%b got %h_%h, want %h",
                         i, ra8, rb8, rs, hi8, lo8, ref16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_width8();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
